// File: rtl/query_port_arbiter_pkg.sv
// Shared pipeline definitions: status encodings seen by the read RAM and lookup field widths.
package query_port_arbiter_pkg;

  typedef enum logic [5:0] {
    FInit  = 6'd0,
    FRun   = 6'd1,
    FBreak = 6'd2,
    BInit  = 6'd3,
    BRun   = 6'd4,
    Done   = 6'h3F
  } status_e;

  localparam int unsigned PosW   = 7;
  localparam int unsigned ReadW  = 9;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned CountW = 16;

  localparam logic [ByteW-1:0] RspIdle = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first asserted request at or after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int unsigned idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx[IDX_W-1:0];
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/query_port_arbiter.sv
// Shares the read-query port among NUM_REQ requesters with zero-latency round-robin issue and
// routes each RAM byte back to its requester LAT cycles later.
module query_port_arbiter
  import query_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LAT     = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PosW-1:0]  req_position,
  input  logic [NUM_REQ*ReadW-1:0] req_read_num,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [5:0]               status_query,
  output logic [PosW-1:0]          query_position,
  output logic [ReadW-1:0]         query_read_num,
  input  logic [ByteW-1:0]         new_read_query,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [ByteW-1:0]         rsp_query,
  output logic [CountW-1:0]        issue_count
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] id;
  } stage_t;

  stage_t [LAT-1:0]   pipe_q, pipe_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] outstanding_q, outstanding_d;
  logic [CountW-1:0]  issue_count_q, issue_count_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic               issue;
  logic               rsp_fire;

  // Gating eligibility with reset_n keeps every issue-side output in its idle state during reset.
  assign eligible = req_valid & ~outstanding_q & {NUM_REQ{reset_n}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (issue)
  );

  assign rsp_fire = reset_n && pipe_q[LAT-1].valid;

  always_comb begin
    req_ready      = gnt;
    status_query   = issue ? BRun : Done;
    query_position = '0;
    query_read_num = '0;
    if (issue) begin
      query_position = req_position[PosW*32'(gnt_idx) +: PosW];
      query_read_num = req_read_num[ReadW*32'(gnt_idx) +: ReadW];
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_query = RspIdle;
    if (rsp_fire) begin
      rsp_valid[pipe_q[LAT-1].id] = 1'b1;
      rsp_query                   = new_read_query;
    end
  end

  assign issue_count = issue_count_q;

  always_comb begin
    pipe_d          = '0;
    pipe_d[0].valid = issue;
    pipe_d[0].id    = gnt_idx;
    for (int unsigned s = 1; s < LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end

    // A requester's bit stays set through its response cycle, so re-grant waits one more cycle.
    outstanding_d = outstanding_q;
    if (rsp_fire) begin
      outstanding_d[pipe_q[LAT-1].id] = 1'b0;
    end
    if (issue) begin
      outstanding_d = outstanding_d | gnt;
    end

    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);
    end

    issue_count_d = issue_count_q;
    if (issue && (issue_count_q != '1)) begin
      issue_count_d = issue_count_q + CountW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_q        <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      issue_count_q <= '0;
    end else begin
      pipe_q        <= pipe_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      issue_count_q <= issue_count_d;
    end
  end

endmodule

// File: tb/tb_query_port_arbiter.sv
// Bench for query_port_arbiter: cycle-indexed reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_query_port_arbiter;

  localparam int N = 4;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*7-1:0] req_position = '0;
  logic [N*9-1:0] req_read_num = '0;
  logic [N-1:0]   req_ready;
  logic [5:0]     status_query;
  logic [6:0]     query_position;
  logic [8:0]     query_read_num;
  logic [7:0]     new_read_query = 8'h00;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_query;
  logic [15:0]    issue_count;

  query_port_arbiter #(
    .NUM_REQ (N),
    .LAT     (L)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_position   (req_position),
    .req_read_num   (req_read_num),
    .req_ready      (req_ready),
    .status_query   (status_query),
    .query_position (query_position),
    .query_read_num (query_read_num),
    .new_read_query (new_read_query),
    .rsp_valid      (rsp_valid),
    .rsp_query      (rsp_query),
    .issue_count    (issue_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state, in terms of cycle numbers rather than registers.
  int cyc = 0;
  int rr_m = 0;
  bit issued_m[N];
  int last_issue[N];
  int due_id[int];
  int count_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    int i;
    if (!reset_n) return -1;
    for (int k = 0; k < N; k++) begin
      i = (rr_m + k) % N;
      if (req_valid[i] && !(issued_m[i] && cyc <= last_issue[i] + L)) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_grant();
    if (!reset_n) begin
      rr_m = 0;
      for (int i = 0; i < N; i++) issued_m[i] = 1'b0;
      due_id.delete();
      count_m = 0;
    end else if (g >= 0) begin
      rr_m = (g + 1) % N;
      issued_m[g] = 1'b1;
      last_issue[g] = cyc;
      due_id[cyc + L] = g;
      if (count_m < 65535) count_m++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    int g;
    logic [31:0] e_rdy, e_st, e_pos, e_rd, e_rsp, e_q;
    g = model_grant();
    e_rdy = 0;
    e_st  = 32'h3F;
    e_pos = 0;
    e_rd  = 0;
    if (g >= 0) begin
      e_rdy = 32'(1) << g;
      e_st  = 32'd4;
      e_pos = 32'(req_position[7*g +: 7]);
      e_rd  = 32'(req_read_num[9*g +: 9]);
    end
    e_rsp = 0;
    e_q   = 32'hFF;
    if (reset_n && due_id.exists(cyc)) begin
      e_rsp = 32'(1) << due_id[cyc];
      e_q   = 32'(new_read_query);
    end
    check("req_ready", 32'(req_ready), e_rdy);
    check("status_query", 32'(status_query), e_st);
    check("query_position", 32'(query_position), e_pos);
    check("query_read_num", 32'(query_read_num), e_rd);
    check("rsp_valid", 32'(rsp_valid), e_rsp);
    check("rsp_query", 32'(rsp_query), e_q);
    check("issue_count", 32'(issue_count), 32'(count_m));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    new_read_query = 8'($urandom);
  endtask

  task automatic set_req(input int i, input int pos, input int rd);
    req_position[7*i +: 7] = 7'(pos);
    req_read_num[9*i +: 9] = 9'(rd);
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_status", 32'(status_query), 32'h3F);
    check("rst_rsp_query", 32'(rsp_query), 32'hFF);
    tick();
    tick();
    reset_n = 1'b1;

    // Single request
    set_req(0, 37, 5);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_status", 32'(status_query), 32'd4);
    check("single_pos", 32'(query_position), 32'd37);
    check("single_read", 32'(query_read_num), 32'd5);
    tick();
    req_valid = '0;
    tick();
    tick();
    new_read_query = 8'h5A;
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_query", 32'(rsp_query), 32'h5A);
    tick();
    @(negedge clk);
    check("single_count", 32'(issue_count), 32'd1);

    // All four requesting from rr_ptr = 0
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 10 + i, 100 + i);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1) << (k % N));
      if (k == 3) check("rr_rsp0", 32'(rsp_valid), 32'h1);
      tick();
    end

    // Back-to-back issues to 2 then 3
    do_reset();
    set_req(2, 22, 200);
    set_req(3, 33, 300);
    req_valid = 4'b1100;
    @(negedge clk);
    check("b2b_grant2", 32'(req_ready), 32'h4);
    tick();
    @(negedge clk);
    check("b2b_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    new_read_query = 8'hA2;
    @(negedge clk);
    check("b2b_rsp2", 32'(rsp_valid), 32'h4);
    check("b2b_byte2", 32'(rsp_query), 32'hA2);
    tick();
    new_read_query = 8'hB3;
    @(negedge clk);
    check("b2b_rsp3", 32'(rsp_valid), 32'h8);
    check("b2b_byte3", 32'(rsp_query), 32'hB3);
    tick();

    // Requester 1 holds req_valid while outstanding
    do_reset();
    set_req(1, 11, 17);
    req_valid = 4'b0010;
    @(negedge clk);
    check("hold_first", 32'(req_ready), 32'h2);
    for (int k = 1; k <= L; k++) begin
      tick();
      @(negedge clk);
      check("hold_blocked", 32'(req_ready), 32'h0);
      if (k == L) check("hold_rsp", 32'(rsp_valid), 32'h2);
    end
    tick();
    @(negedge clk);
    check("hold_regrant", 32'(req_ready), 32'h2);
    tick();

    // Reset one cycle after an issue discards the lookup
    do_reset();
    set_req(0, 1, 2);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("flush_rsp", 32'(rsp_valid), 32'h0);
      check("flush_count", 32'(issue_count), 32'h0);
      tick();
    end

    // Saturation of issue_count: one issue per cycle with four requesters and LAT = 3
    do_reset();
    req_valid = 4'b1111;
    repeat (65535) tick();
    @(negedge clk);
    check("sat_reached", 32'(issue_count), 32'hFFFF);
    repeat (3) tick();
    @(negedge clk);
    check("sat_hold", 32'(issue_count), 32'hFFFF);
    check("sat_still_issuing", 32'(status_query), 32'd4);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
